// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - state encoding and widths shared by the game_ctl match sequencer
package game_pkg;
  localparam int SCORE_W     = 4;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    GOAL   = 3'd3,
    OVER   = 3'd4,
    PAUSED = 3'd5
  } state_t;
endpackage

// File: rtl/game_ctl_if.sv
// rtl/game_ctl_if.sv - game_ctl signal bundle; master drives inputs, slave is the sequencer
interface game_ctl_if;
  import game_pkg::*;

  logic               vblnk_in;
  logic               start;
  logic               pause;
  logic               goal_p1;
  logic               goal_p2;
  logic               ball_run;
  logic               ball_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] player_1_score;
  logic [SCORE_W-1:0] player_2_score;
  logic               game_over;
  logic               winner;
  logic [2:0]         state_out;

  modport master (
    output vblnk_in, start, pause, goal_p1, goal_p2,
    input  ball_run, ball_reset, serve_dir, player_1_score, player_2_score,
           game_over, winner, state_out
  );

  modport slave (
    input  vblnk_in, start, pause, goal_p1, goal_p2,
    output ball_run, ball_reset, serve_dir, player_1_score, player_2_score,
           game_over, winner, state_out
  );
endinterface

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - rising-edge detector against a one-cycle-delayed copy of d
module edge_rise (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk_in) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/game_ctl.sv
// rtl/game_ctl.sv - air-hockey match sequencer: serve/play/goal timing and scores
// Optional pause state enabled by defining GAME_CTL_PAUSE_EN.
module game_ctl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int GOAL_FRAMES  = 90
) (
  input logic       clk_in,
  input logic       rst,
  game_ctl_if.slave bus
);
  localparam logic [SCORE_W-1:0]     WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] GOAL_LAST  = FRAME_CNT_W'(GOAL_FRAMES - 1);

  logic frame_tick, start_rise, pause_rise;

  edge_rise u_vblnk (.clk_in(clk_in), .rst(rst), .d(bus.vblnk_in), .rise(frame_tick));
  edge_rise u_start (.clk_in(clk_in), .rst(rst), .d(bus.start),    .rise(start_rise));
  edge_rise u_pause (.clk_in(clk_in), .rst(rst), .d(bus.pause),    .rise(pause_rise));

`ifndef GAME_CTL_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_rise;
`endif

  state_t                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0]     p1_q, p1_d, p2_q, p2_d;
  logic                   run_q, run_d, rstb_q, rstb_d;
  logic                   serve_q, serve_d, over_q, over_d, win_q, win_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      run_q   <= 1'b0;
      rstb_q  <= 1'b0;
      serve_q <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      run_q   <= run_d;
      rstb_q  <= rstb_d;
      serve_q <= serve_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, OVER: if (start_rise) state_d = SERVE;
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = PLAY;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        if (bus.goal_p1 || bus.goal_p2) state_d = GOAL;
`ifdef GAME_CTL_PAUSE_EN
        else if (pause_rise)            state_d = PAUSED;
`endif
      end
      GOAL: begin
        if (frame_tick) begin
          if (cnt_q == GOAL_LAST) state_d = (p1_q == WIN || p2_q == WIN) ? OVER : SERVE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
`ifdef GAME_CTL_PAUSE_EN
      PAUSED: if (pause_rise) state_d = PLAY;
`endif
      default: state_d = IDLE;
    endcase
    // every state entry restarts the frame count; PAUSED leaves it untouched
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    serve_d = serve_q;
    over_d  = over_q;
    win_d   = win_q;
    run_d   = (state_d == PLAY);
    rstb_d  = (state_d == SERVE) && (state_q != SERVE);
    case (state_q)
      IDLE, OVER: begin
        if (state_d == SERVE) begin
          p1_d    = '0;
          p2_d    = '0;
          serve_d = 1'b0;
          over_d  = 1'b0;
        end
      end
      PLAY: begin
        if (state_d == GOAL) begin
          // simultaneous goals credit player 1 only
          if (bus.goal_p1) begin
            p1_d    = p1_q + 1'b1;
            serve_d = 1'b1;
          end else begin
            p2_d    = p2_q + 1'b1;
            serve_d = 1'b0;
          end
        end
      end
      GOAL: begin
        if (state_d == OVER) begin
          over_d = 1'b1;
          win_d  = (p2_q == WIN);
        end
      end
      default: ;
    endcase
  end

  assign bus.ball_run       = run_q;
  assign bus.ball_reset     = rstb_q;
  assign bus.serve_dir      = serve_q;
  assign bus.player_1_score = p1_q;
  assign bus.player_2_score = p2_q;
  assign bus.game_over      = over_q;
  assign bus.winner         = win_q;
  assign bus.state_out      = state_q;
endmodule

// File: doc/game_ctl.md
Name: game_ctl

Overview:
- Match sequencer for the air-hockey game.
- Sits between the ball-control logic and the score display, in the clk_out_65MHz domain.
- Counts frames from vblnk, gates ball motion, requests ball re-centering, and keeps both scores.
- Decides the serve direction and detects end of match.

Parameters:
- WIN_SCORE, 7: goals needed to win; legal range 1..15.
- SERVE_FRAMES, 60: frames the ball stays frozen before play resumes; legal range 1..255.
- GOAL_FRAMES, 90: frames of post-goal freeze; legal range 1..255.

Ports:
- clk_in  in  1  pixel clock (65 MHz).
- rst  in  1  synchronous, active-high reset.
- vblnk_in  in  1  vertical blank from the timing chain; each rising edge is one frame tick.
- start  in  1  start/restart level (button or mouse click), already synchronous.
- pause  in  1  pause toggle level; used only with PAUSE_EN.
- goal_p1  in  1  one-cycle pulse: player 1 scored.
- goal_p2  in  1  one-cycle pulse: player 2 scored.
- ball_run  out  1  ball may move.
- ball_reset  out  1  one-cycle pulse: re-center the ball.
- serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2.
- player_1_score  out  4  score of player 1.
- player_2_score  out  4  score of player 2.
- game_over  out  1  match finished.
- winner  out  1  0 = player 1, 1 = player 2; valid only while game_over = 1.
- state_out  out  3  current state encoding, for debug.

Behaviour:
- Synchronous, active-high reset. All outputs are registered.
- Reset values: state IDLE, both scores 0, ball_run 0, ball_reset 0, serve_dir 0, game_over 0, winner 0, frame counter 0.
- Edge detection: rising edges of vblnk_in, start and pause are found against a one-cycle-delayed copy.
  - An input high at edge N that was low at edge N-1 counts as an edge at N.
  - State and outputs update at edge N.
- IDLE:
  - ball_run 0.
  - On a start edge: clear scores, serve_dir <= 0, ball_reset pulse, go to SERVE.
- SERVE:
  - ball_run 0.
  - The frame counter increments on each frame tick.
  - When the count reaches SERVE_FRAMES: clear the counter and go to PLAY. ball_run is 1 from the following cycle.
- PLAY:
  - ball_run 1.
  - On goal_p1:
    - player_1_score increments, serve_dir <= 1 (toward the conceding player 2).
    - ball_run 0, go to GOAL.
  - On goal_p2: the mirror image, with serve_dir <= 0.
  - If goal_p1 and goal_p2 arrive in the same cycle: goal_p1 wins and goal_p2 is discarded.
- GOAL:
  - ball_run 0; count GOAL_FRAMES frame ticks.
  - On completion, if either score equals WIN_SCORE:
    - game_over <= 1; winner <= scorer; go to OVER.
  - Otherwise: ball_reset pulse, go to SERVE.
- OVER:
  - ball_run 0, game_over 1; scores are held.
  - On a start edge: clear scores, game_over <= 0, serve_dir <= 0, ball_reset pulse, go to SERVE.
- Inputs ignored by state:
  - Goal pulses outside PLAY are ignored.
  - Start edges outside IDLE and OVER are ignored.
- Counter and score width:
  - The frame counter is 8 bits and is cleared on every state entry.
  - Scores never exceed WIN_SCORE (OVER is entered first), so there is no 4-bit wrap.
- ball_reset is exactly one cycle wide and is never asserted in two consecutive cycles.
- A reset asserted mid-match returns to IDLE within one cycle.

Optional Feature:
- Macro: GAME_CTL_PAUSE_EN.
- With the macro defined:
  - A pause edge in PLAY moves to state PAUSED: ball_run 0, the frame counter is frozen, goal pulses are ignored.
  - The next pause edge returns to PLAY with ball_run 1.
  - A start edge in PAUSED is ignored; reset exits to IDLE.
- Without the macro:
  - The pause port exists but is unused.
  - The PAUSED encoding is never reached.

Decomposition:
- Package game_pkg holds:
  - the state encoding: IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4, PAUSED=5;
  - SCORE_W=4 and FRAME_CNT_W=8.
- One sub-module, edge_rise: a registered rising-edge detector with ports clk_in, rst, d, rise. It is instantiated three times (vblnk_in, start, pause).

Test Plan:
Test parameters unless noted otherwise: WIN_SCORE=2, SERVE_FRAMES=2, GOAL_FRAMES=3.
- Reset, then start edge:
  - In the same cycle the start edge is seen: ball_reset=1 (one cycle) and state=SERVE.
  - After 2 vblnk edges: ball_run=1 and state=PLAY.
- goal_p1 pulse in PLAY:
  - player_1_score=1, serve_dir=1, ball_run=0.
  - After 3 vblnk edges: ball_reset pulse and SERVE.
- goal_p1 and goal_p2 in the same cycle: player_1_score +1, player_2_score unchanged.
- Two goal_p2 goals: after GOAL_FRAMES, game_over=1, winner=1, scores 0/2. Then a start edge: scores 0/0, game_over=0, SERVE.
- goal_p2 pulses during SERVE and GOAL, and start edges during PLAY: no state or score change.
- Pause, with GAME_CTL_PAUSE_EN defined:
  - A pause edge in PLAY gives ball_run=0 and state=5. goal_p1 pulses are ignored.
  - A second pause edge returns to PLAY.
  - A reset asserted while in PAUSED gives IDLE with scores 0/0.
